// File: rtl/regfile_wb_sequencer_pkg.sv
// Shared encodings for the 8-bit core: instruction classes, mem_IO
// subfunctions and the writeback sequencer state set.
package core_pkg;

  localparam logic [3:0] KIND_RR  = 4'b0000;
  localparam logic [3:0] KIND_RI  = 4'b0001;
  localparam logic [3:0] KIND_SH  = 4'b0010;
  localparam logic [3:0] KIND_MEM = 4'b0011;
  localparam logic [3:0] KIND_NOP = 4'b1111;

  localparam logic [1:0] FN2_LOAD  = 2'b00;
  localparam logic [1:0] FN2_STORE = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // ALU-class instructions go through EXEC before writeback.
  function automatic logic is_alu_kind(input logic [3:0] k);
    return (k == KIND_RR) || (k == KIND_RI) || (k == KIND_SH);
  endfunction

  // Only load and store start a memory transaction; other fn2 codes retire.
  function automatic logic is_mem_fn(input logic [1:0] f);
    return (f == FN2_LOAD) || (f == FN2_STORE);
  endfunction

endpackage

// File: rtl/regfile_wb_sequencer_if.sv
// Instruction handshake, memory handshake and register-file control bundle.
interface regfile_wb_sequencer_if #(
  parameter int ADDR_W = 3
);
  logic              ins_valid;
  logic              ins_ready;
  logic [3:0]        kind;
  logic [1:0]        fn2;
  logic [ADDR_W-1:0] waddr_in;
  logic              mem_ack;
  logic              mem_req;
  logic              mem_we;
  logic              ck2;
  logic [3:0]        kind_q;
  logic [1:0]        fn2_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              wsel;
  logic              busy;
  logic              err;

  // Decoder / memory unit / register file side.
  modport master (
    output ins_valid, kind, fn2, waddr_in, mem_ack,
    input  ins_ready, mem_req, mem_we, ck2, kind_q, fn2_q, waddr_q, wsel, busy, err
  );

  // Sequencer side.
  modport slave (
    input  ins_valid, kind, fn2, waddr_in, mem_ack,
    output ins_ready, mem_req, mem_we, ck2, kind_q, fn2_q, waddr_q, wsel, busy, err
  );
endinterface

// File: rtl/regfile_wb_sequencer_mem_timeout_ctr.sv
// Memory-wait timeout counter: clear wins over enable; done flags the
// cycle in which the count would reach MEM_TMO.
module mem_timeout_ctr #(
  parameter int TMO_W   = 4,
  parameter int MEM_TMO = 15
) (
  input  logic ck,
  input  logic res,
  input  logic clr,
  input  logic en,
  output logic done
);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  // Next count: hold, clear or advance.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge ck) begin
    if (!res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == TMO_W'(MEM_TMO - 1));

endmodule

// File: rtl/regfile_wb_sequencer.sv
// Multi-cycle DECODE/EXEC/MEM/WB sequencer for the 8-register file.
module regfile_wb_sequencer
  import core_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int TMO_W   = 4,
  parameter int MEM_TMO = 15
) (
  input  logic                   ck,
  input  logic                   res,
  regfile_wb_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  logic [3:0]        kind_q, kind_d;
  logic [1:0]        fn2_q, fn2_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              wsel_q, wsel_d;
  logic              ck2_q, ck2_d;
  logic              err_q, err_d;
  logic              tmo_clr, tmo_en, tmo_done;

  mem_timeout_ctr #(
    .TMO_W   (TMO_W),
    .MEM_TMO (MEM_TMO)
  ) u_tmo (
    .ck   (ck),
    .res  (res),
    .clr  (tmo_clr),
    .en   (tmo_en),
    .done (tmo_done)
  );

  // Next-state, latch updates and one-cycle strobes (ck2 low, err) for the next cycle.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    fn2_d   = fn2_q;
    waddr_d = waddr_q;
    wsel_d  = wsel_q;
    ck2_d   = 1'b1;
    err_d   = 1'b0;
    tmo_clr = 1'b1;
    tmo_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ins_valid) begin
          kind_d  = bus.kind;
          fn2_d   = bus.fn2;
          waddr_d = bus.waddr_in;
          wsel_d  = 1'b0;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (is_alu_kind(kind_q)) begin
          state_d = ST_EXEC;
        end else if ((kind_q == KIND_MEM) && is_mem_fn(fn2_q)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        wsel_d  = 1'b0;
        ck2_d   = (waddr_q == '0);
        state_d = ST_WB;
      end
      ST_MEM: begin
        // Ack is checked before the timeout so a coincident ack wins.
        if (bus.mem_ack) begin
          if (fn2_q == FN2_LOAD) begin
            wsel_d  = 1'b1;
            ck2_d   = (waddr_q == '0);
            state_d = ST_WB;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tmo_done) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_clr = 1'b0;
          tmo_en  = 1'b1;
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched register-file controls, synchronous active-low reset.
  always_ff @(posedge ck) begin
    if (!res) begin
      state_q <= ST_IDLE;
      kind_q  <= KIND_NOP;
      fn2_q   <= 2'b00;
      waddr_q <= '0;
      wsel_q  <= 1'b0;
      ck2_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      fn2_q   <= fn2_d;
      waddr_q <= waddr_d;
      wsel_q  <= wsel_d;
      ck2_q   <= ck2_d;
      err_q   <= err_d;
    end
  end

  assign bus.ins_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.mem_req   = (state_q == ST_MEM);
  assign bus.mem_we    = (state_q == ST_MEM) && (fn2_q == FN2_STORE);
  assign bus.ck2       = ck2_q;
  assign bus.err       = err_q;
  assign bus.wsel      = wsel_q;
  assign bus.kind_q    = kind_q;
  assign bus.fn2_q     = fn2_q;
  assign bus.waddr_q   = waddr_q;

endmodule
